coin_pulse_gen: RTL and testbench



---
 rtl/vend_pkg.sv | 20 ++
 rtl/coin_pulse_gen_if.sv | 24 ++
 rtl/coin_debounce.sv | 59 +++++
 rtl/coin_pulse_gen.sv | 116 +++++++++++
 tb/tb_coin_pulse_gen.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vend2 vending machine and its coin front-end:
// coin type encoding, default front-end sizing and the vend2 state encoding.
package vend_pkg;

  localparam logic COIN_NICKEL = 1'b0;
  localparam logic COIN_DIME   = 1'b1;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int QUEUE_DEPTH_DEF     = 4;

  // Credit accumulated by vend2 so far; DISPENSE is the state that drives Dispense.
  typedef enum logic [2:0] {
    ST_CENTS_0  = 3'd0,
    ST_CENTS_5  = 3'd1,
    ST_CENTS_10 = 3'd2,
    ST_CENTS_15 = 3'd3,
    ST_DISPENSE = 3'd4
  } vend_state_e;

endpackage

// File: rtl/coin_pulse_gen_if.sv
// Sensor, credit and status signals between the coin front-end and its neighbours.
interface coin_pulse_gen_if #(
  parameter int CNT_W = 3
);

  logic             NickelRaw;
  logic             DimeRaw;
  logic             Busy;
  logic             Nickel;
  logic             Dime;
  logic [CNT_W-1:0] Count;
  logic             Overflow;

  modport master (
    output NickelRaw, DimeRaw, Busy,
    input  Nickel, Dime, Count, Overflow
  );

  modport slave (
    input  NickelRaw, DimeRaw, Busy,
    output Nickel, Dime, Count, Overflow
  );

endinterface

// File: rtl/coin_debounce.sv
// One coin sensor: 2-flop synchronizer, stability filter and arm bit.
// coin_evt is high for the single cycle after an armed filtered rising edge.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic Reset,
  input  logic raw,
  output logic coin_evt
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic [1:0]      vld_r;
  logic [DB_W-1:0] cnt_r;
  logic            filt_r;
  logic            filt_d_r;
  logic            arm_r;

  // Synchronize, filter and arm; vld_r marks sync2_r as holding a real sensor sample
  // so the reset-cleared synchronizer cannot arm a line held high through reset.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      vld_r    <= 2'b00;
      cnt_r    <= '0;
      filt_r   <= 1'b0;
      filt_d_r <= 1'b0;
      arm_r    <= 1'b0;
    end else begin
      sync1_r  <= raw;
      sync2_r  <= sync1_r;
      vld_r    <= {vld_r[0], 1'b1};
      filt_d_r <= filt_r;
      if (sync2_r != filt_r) begin
        if (cnt_r == DB_LAST) begin
          filt_r <= ~filt_r;
          cnt_r  <= '0;
        end else begin
          cnt_r <= cnt_r + DB_W'(1);
        end
      end else begin
        cnt_r <= '0;
      end
      if (!filt_r && !sync2_r && vld_r[1]) begin
        arm_r <= 1'b1;
      end else begin
        arm_r <= arm_r;
      end
    end
  end

  assign coin_evt = filt_r & ~filt_d_r & arm_r;

endmodule

// File: rtl/coin_pulse_gen.sv
// Coin front-end for vend2: debounced sensors feed a small coin FIFO that issues
// spaced single-cycle Nickel/Dime credit pulses whenever vend2 is not dispensing.
module coin_pulse_gen
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int QUEUE_DEPTH     = QUEUE_DEPTH_DEF,
  parameter int CNT_W           = 3
) (
  input logic            CLK,
  input logic            Reset,
  coin_pulse_gen_if.slave bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  logic             nick_evt_s;
  logic             dime_evt_s;
  logic             any_evt_s;
  logic             both_evt_s;
  logic             pop_s;
  logic             push0_s;
  logic             push1_s;
  logic             type0_s;
  logic             drop_s;
  logic             head_s;
  logic [CNT_W:0]   room_s;
  logic [PTR_W:0]   wptr_nxt1_s;

  logic             fifo_r [QUEUE_DEPTH];
  logic [PTR_W:0]   wptr_r;
  logic [PTR_W:0]   rptr_r;
  logic [CNT_W-1:0] count_r;
  logic             nickel_r;
  logic             dime_r;
  logic             gap_r;
  logic             ovf_r;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nickel (
    .CLK      (CLK),
    .Reset    (Reset),
    .raw      (bus.NickelRaw),
    .coin_evt (nick_evt_s)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dime (
    .CLK      (CLK),
    .Reset    (Reset),
    .raw      (bus.DimeRaw),
    .coin_evt (dime_evt_s)
  );

  assign head_s = fifo_r[rptr_r[PTR_W-1:0]];

  // Issue and enqueue decisions; a same-cycle pop frees a slot for an incoming coin,
  // and with one slot left the nickel of a simultaneous pair wins.
  always_comb begin
    any_evt_s   = nick_evt_s | dime_evt_s;
    both_evt_s  = nick_evt_s & dime_evt_s;
    pop_s       = (wptr_r != rptr_r) & ~bus.Busy & ~gap_r;
    room_s      = (CNT_W+1)'(QUEUE_DEPTH) - {1'b0, count_r} + {{CNT_W{1'b0}}, pop_s};
    push0_s     = any_evt_s & (room_s != '0);
    push1_s     = both_evt_s & (room_s >= (CNT_W+1)'(2));
    drop_s      = (any_evt_s & ~push0_s) | (both_evt_s & ~push1_s);
    wptr_nxt1_s = wptr_r + (PTR_W+1)'(1);
    if (nick_evt_s) begin
      type0_s = COIN_NICKEL;
    end else begin
      type0_s = COIN_DIME;
    end
  end

  // Coin type storage; a second write in the same cycle is always the dime.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        fifo_r[i] <= COIN_NICKEL;
      end
    end else begin
      if (push0_s) begin
        fifo_r[wptr_r[PTR_W-1:0]] <= type0_s;
      end
      if (push1_s) begin
        fifo_r[wptr_nxt1_s[PTR_W-1:0]] <= COIN_DIME;
      end
    end
  end

  // Pointers, occupancy, sticky overflow and the registered credit pulses.
  // gap_r follows each pulse so vend2 can raise Dispense before the next issue.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      count_r  <= '0;
      nickel_r <= 1'b0;
      dime_r   <= 1'b0;
      gap_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      wptr_r   <= wptr_r + (PTR_W+1)'(push0_s) + (PTR_W+1)'(push1_s);
      rptr_r   <= rptr_r + (PTR_W+1)'(pop_s);
      count_r  <= count_r + CNT_W'(push0_s) + CNT_W'(push1_s) - CNT_W'(pop_s);
      nickel_r <= pop_s & (head_s == COIN_NICKEL);
      dime_r   <= pop_s & (head_s == COIN_DIME);
      gap_r    <= pop_s;
      ovf_r    <= ovf_r | drop_s;
    end
  end

  assign bus.Nickel   = nickel_r;
  assign bus.Dime     = dime_r;
  assign bus.Count    = count_r;
  assign bus.Overflow = ovf_r;

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Randomized bench for coin_pulse_gen against a queue-based behavioural model
// of sensor filtering, coin ordering, spaced issue and overflow.
module tb_coin_pulse_gen;

  localparam int DB = 4;
  localparam int QD = 4;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  coin_pulse_gen_if #(.CNT_W(3)) bus_if ();

  coin_pulse_gen #(.DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(QD), .CNT_W(3)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_if.slave)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc_no = 0;
  int n_pulses = 0;
  int d_pulses = 0;
  int first_nick = -1;
  int peak_cnt = 0;

  // Model: edges since reset, raw history and synced samples per line, filtered level,
  // edge of last filter change, arm flag, pending event, coin queue and outputs.
  int m_n;
  bit m_raw[2][$];
  bit m_smp[2][$];
  bit m_filt[2];
  int m_flip[2];
  bit m_arm[2];
  bit m_evt[2];
  bit m_q[$];
  bit m_nick, m_dime, m_ovf;

  task automatic chk(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc_no);
  endtask

  task automatic model_step(input bit nr, input bit dr, input bit busy, input bit rst);
    bit pop, head, smp, real_smp, all_diff;
    int room;
    bit in_raw[2];
    if (!rst) begin
      m_n = 0;
      for (int i = 0; i < 2; i++) begin
        m_raw[i].delete(); m_smp[i].delete();
        m_filt[i] = 0; m_flip[i] = 0; m_arm[i] = 0; m_evt[i] = 0;
      end
      m_q.delete(); m_nick = 0; m_dime = 0; m_ovf = 0;
      return;
    end
    m_n++;
    // issue: one coin per pulse, never while busy or in the cycle of a pulse
    pop = (m_q.size() > 0) && !busy && !(m_nick || m_dime);
    head = pop ? m_q[0] : 1'b0;
    room = QD - m_q.size() + (pop ? 1 : 0);
    if (pop) void'(m_q.pop_front());
    m_nick = pop && (head == 1'b0);
    m_dime = pop && (head == 1'b1);
    // enqueue coins detected in the previous cycle, nickel first
    for (int i = 0; i < 2; i++) begin
      if (m_evt[i]) begin
        if (room > 0) begin m_q.push_back(i[0]); room--; end
        else m_ovf = 1;
      end
    end
    // sensor filtering: a level change needs DB consecutive differing synced samples
    in_raw[0] = nr; in_raw[1] = dr;
    for (int i = 0; i < 2; i++) begin
      real_smp = (m_n >= 3);
      smp = real_smp ? m_raw[i][m_n-3] : 1'b0;
      m_smp[i].push_back(smp);
      m_evt[i] = 0;
      if (!m_filt[i] && real_smp && !smp) m_arm[i] = 1;
      if (m_n - m_flip[i] >= DB) begin
        all_diff = 1;
        for (int k = 0; k < DB; k++)
          if (m_smp[i][m_smp[i].size()-1-k] == m_filt[i]) all_diff = 0;
        if (all_diff) begin
          m_filt[i] = ~m_filt[i];
          m_flip[i] = m_n;
          m_evt[i] = m_filt[i] && m_arm[i];
        end
      end
      m_raw[i].push_back(in_raw[i]);
    end
  endtask

  task automatic cyc(input bit nr, input bit dr, input bit busy, input bit rst);
    bus_if.NickelRaw = nr;
    bus_if.DimeRaw   = dr;
    bus_if.Busy      = busy;
    Reset            = rst;
    @(posedge CLK);
    cyc_no++;
    model_step(nr, dr, busy, rst);
    #1;
    chk("Nickel", int'(bus_if.Nickel), int'(m_nick));
    chk("Dime", int'(bus_if.Dime), int'(m_dime));
    chk("Count", int'(bus_if.Count), m_q.size());
    chk("Overflow", int'(bus_if.Overflow), int'(m_ovf));
    chk("exclusive", int'(bus_if.Nickel & bus_if.Dime), 0);
    if (bus_if.Nickel) begin
      n_pulses++;
      if (first_nick < 0) first_nick = cyc_no;
    end
    if (bus_if.Dime) d_pulses++;
    if (int'(bus_if.Count) > peak_cnt) peak_cnt = int'(bus_if.Count);
  endtask

  task automatic clr_stats();
    n_pulses = 0; d_pulses = 0; first_nick = -1; peak_cnt = 0;
  endtask

  task automatic nickels_busy(input int n);
    for (int c = 0; c < n; c++) begin
      repeat (6) cyc(1, 0, 1, 1);
      repeat (6) cyc(0, 0, 1, 1);
    end
  endtask

  initial begin
    int c0;
    bit rn, rd, rb;
    int hn, hd, hb;
    // 1: single nickel, latency from first high sample
    repeat (3) cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1);
    clr_stats();
    c0 = cyc_no + 1;
    repeat (10) cyc(1, 0, 0, 1);
    repeat (10) cyc(0, 0, 0, 1);
    chk("s1_pulses", n_pulses, 1);
    chk("s1_latency", first_nick - c0, DB + 3);
    chk("s1_peak", peak_cnt, 1);
    chk("s1_ovf", int'(bus_if.Overflow), 0);
    // 2: bouncing dime then a clean hold
    clr_stats();
    for (int b = 0; b < 2; b++) begin
      repeat (2) cyc(0, 1, 0, 1);
      repeat (2) cyc(0, 0, 0, 1);
    end
    chk("s2_bounce", d_pulses, 0);
    repeat (10) cyc(0, 1, 0, 1);
    repeat (10) cyc(0, 0, 0, 1);
    chk("s2_pulses", d_pulses, 1);
    // 3: simultaneous coins
    clr_stats();
    repeat (10) cyc(1, 1, 0, 1);
    repeat (10) cyc(0, 0, 0, 1);
    chk("s3_nickel", n_pulses, 1);
    chk("s3_dime", d_pulses, 1);
    // 4: five nickels while busy, then drain
    clr_stats();
    nickels_busy(5);
    chk("s4_count", int'(bus_if.Count), 4);
    chk("s4_ovf", int'(bus_if.Overflow), 1);
    chk("s4_held", n_pulses, 0);
    repeat (15) cyc(0, 0, 0, 1);
    chk("s4_drained", n_pulses, 4);
    chk("s4_empty", int'(bus_if.Count), 0);
    // 5: nickel line held high through reset release
    clr_stats();
    repeat (3) cyc(1, 0, 0, 0);
    repeat (12) cyc(1, 0, 0, 1);
    repeat (8) cyc(0, 0, 0, 1);
    chk("s5_held", n_pulses, 0);
    repeat (8) cyc(1, 0, 0, 1);
    repeat (8) cyc(0, 0, 0, 1);
    chk("s5_later", n_pulses, 1);
    // 6: reset mid-drain
    nickels_busy(4);
    cyc(0, 0, 0, 1);
    chk("s6_pre", int'(bus_if.Count), 3);
    cyc(0, 0, 0, 0);
    chk("s6_count", int'(bus_if.Count), 0);
    chk("s6_ovf", int'(bus_if.Overflow), 0);
    clr_stats();
    repeat (15) cyc(0, 0, 0, 1);
    chk("s6_quiet", n_pulses + d_pulses, 0);
    // 7: randomized sensors, busy and occasional reset
    rn = 0; rd = 0; rb = 0; hn = 0; hd = 0; hb = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hn == 0) begin rn = ~rn; hn = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12); end
      if (hd == 0) begin rd = ~rd; hd = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12); end
      if (hb == 0) begin rb = ~rb; hb = $urandom_range(1, 25); end
      hn--; hd--; hb--;
      cyc(rn, rd, rb, ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
